mem_stage: RTL and testbench



---
 rtl/mem_stage_pkg.sv | 12 +
 rtl/mem_wb_latch.sv | 55 +++++
 rtl/mem_stage.sv | 132 +++++++++++++
 tb/tb_mem_stage.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the memory-access pipeline stage.
package mem_stage_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    localparam int TIMEOUT_DEFAULT = 16;
    localparam int CNT_W           = 8;

endpackage

// File: rtl/mem_wb_latch.sv
// MEM/WB pipeline register set; bubble forces the op to a no-write-back slot.
// With MEM_ALIGN_CHECK_EN defined it also carries the one-cycle AlignErrW flag.
module mem_wb_latch (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        bubble,
    input  logic        busErr,
`ifdef MEM_ALIGN_CHECK_EN
    input  logic        alignErr,
    output logic        AlignErrW,
`endif
    input  logic        regWrite,
    input  logic        memtoReg,
    input  logic        loadEn,
    input  logic [31:0] readData,
    input  logic [31:0] aluOut,
    input  logic [4:0]  writeReg,
    output logic        RegWriteW,
    output logic        MemtoRegW,
    output logic [31:0] ReadDataW,
    output logic [31:0] ALUOutW,
    output logic [4:0]  WriteRegW,
    output logic        BusErrW
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            RegWriteW <= 1'b0;
            MemtoRegW <= 1'b0;
            ReadDataW <= '0;
            ALUOutW   <= '0;
            WriteRegW <= '0;
            BusErrW   <= 1'b0;
        end else begin
            RegWriteW <= regWrite & ~bubble;
            MemtoRegW <= memtoReg & ~bubble;
            ALUOutW   <= aluOut;
            WriteRegW <= writeReg;
            BusErrW   <= busErr;
            // Stores and non-memory ops leave the last load data in place.
            if (loadEn && !bubble)
                ReadDataW <= readData;
        end
    end

`ifdef MEM_ALIGN_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            AlignErrW <= 1'b0;
        else
            AlignErrW <= alignErr;
    end
`endif

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: dmem req/ack handshake, pipeline stall, bus timeout.
// Optional MEM_ALIGN_CHECK_EN rejects misaligned accesses with AlignErrW.
//
// state | meaning
// IDLE  | no access outstanding; a new access may complete with zero wait
// WAIT  | access issued, waiting for dmem_ack or the timeout count
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        RegWriteM,
    input  logic        MemtoRegM,
    input  logic        MemWriteM,
    input  logic [31:0] ALUOutM,
    input  logic [31:0] WriteDataM,
    input  logic [4:0]  WriteRegM,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        StallM,
`ifdef MEM_ALIGN_CHECK_EN
    output logic        AlignErrW,
`endif
    output logic        RegWriteW,
    output logic        MemtoRegW,
    output logic [31:0] ReadDataW,
    output logic [31:0] ALUOutW,
    output logic [4:0]  WriteRegW,
    output logic        BusErrW
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t           state, stateNext;
    logic [CNT_W-1:0] cnt, cntNext;
    logic             memOp;
    logic             access;
    logic             misaligned;
    logic             timeoutHit;
    logic             isLoad;

    // Control is gated by reset so nothing is requested while rst_n is low.
    assign memOp = rst_n & (MemtoRegM | MemWriteM);

`ifdef MEM_ALIGN_CHECK_EN
    assign misaligned = memOp & (ALUOutM[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif

    assign access     = memOp & ~misaligned;
    assign isLoad     = MemtoRegM & ~MemWriteM;
    assign dmem_we    = MemWriteM;
    assign dmem_addr  = ALUOutM;
    assign dmem_wdata = WriteDataM;
    assign StallM     = access & ~dmem_ack & ~timeoutHit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= stateNext;
            cnt   <= cntNext;
        end
    end

    always_comb begin
        stateNext  = state;
        cntNext    = cnt;
        dmem_req   = 1'b0;
        timeoutHit = 1'b0;
        case (state)
            IDLE: begin
                if (access) begin
                    dmem_req = 1'b1;
                    if (!dmem_ack) begin
                        stateNext = WAIT;
                        cntNext   = '0;
                    end
                end
            end
            WAIT: begin
                if (!access) begin
                    stateNext = IDLE;
                end else begin
                    dmem_req = 1'b1;
                    if (dmem_ack) begin
                        stateNext = IDLE;
                    end else if (cnt == CNT_LAST) begin
                        // Ack on the last allowed cycle still wins over the timeout.
                        timeoutHit = 1'b1;
                        stateNext  = IDLE;
                    end else begin
                        cntNext = (cnt == '1) ? cnt : cnt + 1'b1;
                    end
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    mem_wb_latch u_mem_wb_latch (
        .clk       (clk),
        .rst_n     (rst_n),
        .bubble    (StallM | timeoutHit | misaligned),
        .busErr    (timeoutHit),
`ifdef MEM_ALIGN_CHECK_EN
        .alignErr  (misaligned),
        .AlignErrW (AlignErrW),
`endif
        .regWrite  (RegWriteM),
        .memtoReg  (isLoad),
        .loadEn    (access & dmem_ack & isLoad),
        .readData  (dmem_rdata),
        .aluOut    (ALUOutM),
        .writeReg  (WriteRegM),
        .RegWriteW (RegWriteW),
        .MemtoRegW (MemtoRegW),
        .ReadDataW (ReadDataW),
        .ALUOutW   (ALUOutW),
        .WriteRegW (WriteRegW),
        .BusErrW   (BusErrW)
    );

endmodule

// File: tb/tb_mem_stage.sv
// Randomized self-checking bench for mem_stage against a transaction-level model.
// Covers MEM_ALIGN_CHECK_EN when the macro is defined for the build.
module tb_mem_stage;

    localparam int TO = 4;
`ifdef MEM_ALIGN_CHECK_EN
    localparam bit ALIGN_EN = 1'b1;
`else
    localparam bit ALIGN_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        RegWriteM, MemtoRegM, MemWriteM;
    logic [31:0] ALUOutM, WriteDataM;
    logic [4:0]  WriteRegM;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic        StallM;
    logic        RegWriteW, MemtoRegW;
    logic [31:0] ReadDataW, ALUOutW;
    logic [4:0]  WriteRegW;
    logic        BusErrW;
    logic        AlignErrW;

    int errCnt = 0;
    int chkCnt = 0;
    logic [31:0] rdModel = '0;

    always #5 clk = ~clk;

    mem_stage #(.TIMEOUT(TO)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .RegWriteM  (RegWriteM),
        .MemtoRegM  (MemtoRegM),
        .MemWriteM  (MemWriteM),
        .ALUOutM    (ALUOutM),
        .WriteDataM (WriteDataM),
        .WriteRegM  (WriteRegM),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_ack   (dmem_ack),
        .dmem_rdata (dmem_rdata),
        .StallM     (StallM),
`ifdef MEM_ALIGN_CHECK_EN
        .AlignErrW  (AlignErrW),
`endif
        .RegWriteW  (RegWriteW),
        .MemtoRegW  (MemtoRegW),
        .ReadDataW  (ReadDataW),
        .ALUOutW    (ALUOutW),
        .WriteRegW  (WriteRegW),
        .BusErrW    (BusErrW)
    );

`ifndef MEM_ALIGN_CHECK_EN
    assign AlignErrW = 1'b0;
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chkCnt++;
        if (obs !== exp) begin
            errCnt++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic setIdle();
        RegWriteM  = 1'b0;
        MemtoRegM  = 1'b0;
        MemWriteM  = 1'b0;
        ALUOutM    = '0;
        WriteDataM = '0;
        WriteRegM  = '0;
        dmem_ack   = 1'b0;
    endtask

    // Runs one op starting at posedge+1. ackAt = cycle index of the ack
    // (0 = same cycle as issue); ackAt > TO means the memory never answers.
    task automatic doOp(input logic rw, input logic mtr, input logic mw,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [4:0] wr, input int ackAt, input logic [31:0] rdata);
        bit isAcc, mis, eff, timedOut, completed, sawStall, done;
        int k, stalls, expStalls;
        isAcc     = mtr | mw;
        mis       = ALIGN_EN && isAcc && (addr[1:0] != 2'b00);
        eff       = isAcc && !mis;
        timedOut  = eff && (ackAt > TO);
        completed = eff && !timedOut;
        expStalls = eff ? ((ackAt < TO) ? ackAt : TO) : 0;

        RegWriteM  = rw;
        MemtoRegM  = mtr;
        MemWriteM  = mw;
        ALUOutM    = addr;
        WriteDataM = wdata;
        WriteRegM  = wr;
        dmem_rdata = rdata;
        stalls = 0;
        done   = 0;
        k      = 0;
        while (!done) begin
            dmem_ack = eff ? (k == ackAt) : 1'($urandom_range(0, 1));
            #3;
            chk("dmem_req", dmem_req, eff);
            if (eff) begin
                chk("dmem_we", dmem_we, mw);
                chk("dmem_addr", dmem_addr, addr);
                chk("dmem_wdata", dmem_wdata, wdata);
            end
            sawStall = StallM;
            if (sawStall) stalls++;
            @(posedge clk); #1;
            k++;
            if (!sawStall) begin
                done = 1;
            end else begin
                chk("bubble_RegWriteW", RegWriteW, 1'b0);
                chk("bubble_MemtoRegW", MemtoRegW, 1'b0);
                chk("bubble_BusErrW", BusErrW, 1'b0);
                if (k > TO + 3) begin
                    chk("stall_bound", 32'(k), 32'(TO + 1));
                    done = 1;
                end
            end
        end

        chk("stall_cycles", 32'(stalls), 32'(expStalls));
        chk("RegWriteW", RegWriteW, (completed || !isAcc) ? rw : 1'b0);
        chk("MemtoRegW", MemtoRegW, completed ? (mtr & ~mw) : 1'b0);
        chk("BusErrW", BusErrW, timedOut);
        chk("AlignErrW", AlignErrW, mis);
        if (completed || !isAcc) begin
            chk("ALUOutW", ALUOutW, addr);
            chk("WriteRegW", WriteRegW, wr);
        end
        if (completed && mtr && !mw) rdModel = rdata;
        chk("ReadDataW", ReadDataW, rdModel);

        // After an error the flag must last one cycle and the request must drop.
        if (timedOut || mis) begin
            setIdle();
            #3;
            chk("post_err_req", dmem_req, 1'b0);
            @(posedge clk); #1;
            chk("post_err_BusErrW", BusErrW, 1'b0);
            chk("post_err_AlignErrW", AlignErrW, 1'b0);
            chk("post_err_RegWriteW", RegWriteW, 1'b0);
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        setIdle();
        MemtoRegM  = 1'b1;
        RegWriteM  = 1'b1;
        dmem_rdata = '0;
        #2;
        chk("rst_req", dmem_req, 1'b0);
        chk("rst_stall", StallM, 1'b0);
        chk("rst_RegWriteW", RegWriteW, 1'b0);
        chk("rst_ReadDataW", ReadDataW, 32'h0);
        chk("rst_BusErrW", BusErrW, 1'b0);
        chk("rst_AlignErrW", AlignErrW, 1'b0);
        setIdle();
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        doOp(1'b1, 1'b1, 1'b0, 32'h100, 32'h0, 5'd3, 0, 32'hDEADBEEF);
        doOp(1'b0, 1'b0, 1'b1, 32'h204, 32'h12345678, 5'd0, 3, 32'h0BADF00D);
        doOp(1'b1, 1'b1, 1'b0, 32'h300, 32'h0, 5'd9, TO + 1, 32'h11112222);
        doOp(1'b1, 1'b0, 1'b0, 32'h55, 32'h0, 5'd7, 0, 32'h0);
        doOp(1'b1, 1'b1, 1'b0, 32'h102, 32'h0, 5'd4, 1, 32'hCAFEF00D);
        doOp(1'b1, 1'b1, 1'b1, 32'h40, 32'hA5A5A5A5, 5'd5, TO, 32'h77777777);

        // Reset in the second WAIT cycle abandons the access.
        RegWriteM = 1'b1; MemtoRegM = 1'b1; MemWriteM = 1'b0;
        ALUOutM = 32'h480; WriteRegM = 5'd12; dmem_ack = 1'b0;
        dmem_rdata = 32'h99999999;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_req", dmem_req, 1'b0);
        chk("midrst_stall", StallM, 1'b0);
        chk("midrst_RegWriteW", RegWriteW, 1'b0);
        chk("midrst_ReadDataW", ReadDataW, 32'h0);
        rdModel = '0;
        setIdle();
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            dmem_ack = 1'b1;
            #3;
            chk("postrst_req", dmem_req, 1'b0);
            @(posedge clk); #1;
            chk("postrst_RegWriteW", RegWriteW, 1'b0);
            chk("postrst_ReadDataW", ReadDataW, 32'h0);
        end
        dmem_ack = 1'b0;
        doOp(1'b1, 1'b1, 1'b0, 32'h500, 32'h0, 5'd2, 2, 32'h13579BDF);

        for (int t = 0; t < 300; t++) begin
            logic [1:0]  kind;
            logic [31:0] addr;
            kind = 2'($urandom_range(0, 3));
            addr = $urandom;
            if ($urandom_range(0, 3) != 0) addr[1:0] = 2'b00;
            doOp(1'($urandom_range(0, 1)), kind[0], kind[1], addr, $urandom,
                 5'($urandom_range(0, 31)), $urandom_range(0, TO + 2), $urandom);
        end

        $display("Result: errors=%0d of %0d checks", errCnt, chkCnt);
        $finish;
    end

endmodule
